// File: rtl/ubalance_pkg.sv
// ============================================================================
// Module : ubalance_pkg
// Brief  : Shared types for the ubalance running-balance block.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ubalance_pkg;

  typedef logic [7:0] u8;
  typedef u8          U8;
  typedef logic       bool;

  typedef enum logic {OP_CREDIT, OP_DEBIT} op_t;

  typedef enum logic [1:0] {ST_SOLVENT, ST_DEBT, ST_SATURATED} ubal_state_t;

endpackage

`default_nettype wire

// File: rtl/ubalance_if.sv
// ============================================================================
// Module : ubalance_if
// Brief  : Transaction-in / result-out handshake bundle for ubalance.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ubalance_if
  import ubalance_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) ();

  logic                  in_valid;
  logic                  in_ready;
  op_t                   in_op;
  logic [DATA_WIDTH-1:0] in_amt;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_bal;
  logic [DATA_WIDTH-1:0] out_def;
  logic                  out_uf;

  modport master (
    output in_valid, in_op, in_amt, out_ready,
    input  in_ready, out_valid, out_bal, out_def, out_uf
  );

  modport slave (
    input  in_valid, in_op, in_amt, out_ready,
    output in_ready, out_valid, out_bal, out_def, out_uf
  );

endinterface

`default_nettype wire

// File: rtl/ubalance_usub.sv
// ============================================================================
// Module : usub
// Brief  : Clamping unsigned subtract a - b; reports shortfall and underflow.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usub #(
  parameter int DATA_WIDTH = 8
) (
  input  wire logic [DATA_WIDTH-1:0] i_a,
  input  wire logic [DATA_WIDTH-1:0] i_b,
  output      logic [DATA_WIDTH-1:0] o_out,
  output      logic [DATA_WIDTH-1:0] o_underflow,
  output      logic                  o_sig_uf
);

  logic [DATA_WIDTH:0] w_diff;

  assign w_diff      = {1'b0, i_a} - {1'b0, i_b};
  assign o_sig_uf    = w_diff[DATA_WIDTH];
  assign o_out       = o_sig_uf ? '0 : w_diff[DATA_WIDTH-1:0];
  // Borrow set: the low bits hold a-b mod 2^DW, so negate to get b-a.
  assign o_underflow = o_sig_uf ? (~w_diff[DATA_WIDTH-1:0] + 1'b1) : '0;

endmodule

`default_nettype wire

// File: rtl/ubalance.sv
// ============================================================================
// Module : ubalance
// Brief  : Running unsigned balance with deficit tracking over valid/ready.
//          Optional underflow counter enabled by UBALANCE_STATS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ubalance
  import ubalance_pkg::*;
#(
  parameter int DATA_WIDTH = 8
`ifdef UBALANCE_STATS_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  wire logic     clk,
  input  wire logic     rst,
  input  wire logic     clr,
  ubalance_if.slave     bus,
  output      logic     def_sat
`ifdef UBALANCE_STATS_EN
  ,
  output      logic [CNT_WIDTH-1:0] uf_count
`endif
);

  localparam logic [1:0]            c_ST_SOLVENT   = 2'(ST_SOLVENT);
  localparam logic [1:0]            c_ST_DEBT      = 2'(ST_DEBT);
  localparam logic [1:0]            c_ST_SATURATED = 2'(ST_SATURATED);
  localparam logic [DATA_WIDTH-1:0] c_MAX          = '1;

  logic [DATA_WIDTH-1:0] r_bal;
  logic [DATA_WIDTH-1:0] r_def;
  logic                  r_uf;
  logic                  r_out_valid;
  logic                  r_def_sat;
  logic [1:0]            r_state;

  logic                  w_in_ready;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_sub_out;
  logic [DATA_WIDTH-1:0] w_shortfall;
  logic                  w_sig_uf;
  logic [DATA_WIDTH:0]   w_def_sum;
  logic [DATA_WIDTH:0]   w_bal_sum;
  logic [DATA_WIDTH-1:0] w_nxt_bal;
  logic [DATA_WIDTH-1:0] w_nxt_def;
  logic                  w_nxt_uf;
  logic                  w_def_clamp;
  logic [1:0]            w_nxt_state;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready && !clr;

  usub #(.DATA_WIDTH(DATA_WIDTH)) u_usub (
    .i_a         (r_bal),
    .i_b         (bus.in_amt),
    .o_out       (w_sub_out),
    .o_underflow (w_shortfall),
    .o_sig_uf    (w_sig_uf)
  );

  assign w_def_sum = {1'b0, r_def} + {1'b0, w_shortfall};
  // Only used when amt > def, so the DW-bit difference cannot wrap.
  assign w_bal_sum = {1'b0, r_bal} + {1'b0, bus.in_amt - r_def};

  always_comb begin
    w_nxt_bal   = r_bal;
    w_nxt_def   = r_def;
    w_nxt_uf    = 1'b0;
    w_def_clamp = 1'b0;
    if (bus.in_op == OP_DEBIT) begin
      w_nxt_bal = w_sub_out;
      w_nxt_uf  = w_sig_uf;
      if (w_sig_uf) begin
        w_def_clamp = w_def_sum[DATA_WIDTH];
        w_nxt_def   = w_def_clamp ? c_MAX : w_def_sum[DATA_WIDTH-1:0];
      end
    end else begin
      // A solvent account has no deficit to repay.
      if ((r_state != c_ST_SOLVENT) && (r_def >= bus.in_amt)) begin
        w_nxt_def = r_def - bus.in_amt;
      end else begin
        w_nxt_def = '0;
        w_nxt_bal = w_bal_sum[DATA_WIDTH] ? c_MAX : w_bal_sum[DATA_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_nxt_state = c_ST_DEBT;
    if (w_nxt_def == '0) begin
      w_nxt_state = c_ST_SOLVENT;
    end else if (w_nxt_def == c_MAX) begin
      w_nxt_state = c_ST_SATURATED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bal       <= '0;
      r_def       <= '0;
      r_uf        <= 1'b0;
      r_out_valid <= 1'b0;
      r_def_sat   <= 1'b0;
      r_state     <= c_ST_SOLVENT;
    end else if (clr) begin
      r_bal       <= '0;
      r_def       <= '0;
      r_uf        <= 1'b0;
      r_out_valid <= 1'b0;
      r_def_sat   <= 1'b0;
      r_state     <= c_ST_SOLVENT;
    end else if (w_accept) begin
      r_bal       <= w_nxt_bal;
      r_def       <= w_nxt_def;
      r_uf        <= w_nxt_uf;
      r_out_valid <= 1'b1;
      r_def_sat   <= r_def_sat | w_def_clamp;
      r_state     <= w_nxt_state;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef UBALANCE_STATS_EN
  logic [CNT_WIDTH-1:0] r_uf_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_uf_count <= '0;
    end else if (clr) begin
      r_uf_count <= '0;
    end else if (w_accept && w_nxt_uf && (r_uf_count != {CNT_WIDTH{1'b1}})) begin
      r_uf_count <= r_uf_count + 1'b1;
    end
  end

  assign uf_count = r_uf_count;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_bal   = r_bal;
  assign bus.out_def   = r_def;
  assign bus.out_uf    = r_uf;
  assign def_sat       = r_def_sat;

endmodule

`default_nettype wire

// File: tb/tb_ubalance.sv
// ============================================================================
// Module : tb_ubalance
// Brief  : Self-checking bench for ubalance (DW=8) against an arithmetic model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ubalance;
  import ubalance_pkg::*;

  logic clk;
  logic rst;
  logic clr;
  logic def_sat;
`ifdef UBALANCE_STATS_EN
  logic [15:0] uf_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int m_bal = 0;
  int m_def = 0;
  int m_uf  = 0;
  int m_sat = 0;
  int m_cnt = 0;

  ubalance_if #(.DATA_WIDTH(8)) bus ();

  ubalance #(
    .DATA_WIDTH(8)
`ifdef UBALANCE_STATS_EN
    ,
    .CNT_WIDTH(16)
`endif
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .bus     (bus),
    .def_sat (def_sat)
`ifdef UBALANCE_STATS_EN
    ,
    .uf_count(uf_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_state();
    if (m_def == 0) return 0;
    if (m_def == 255) return 2;
    return 1;
  endfunction

  task automatic model_zero();
    m_bal = 0; m_def = 0; m_uf = 0; m_sat = 0; m_cnt = 0;
  endtask

  task automatic model(input op_t op, input int a);
    int t;
    if (op == OP_DEBIT) begin
      if (m_bal >= a) begin
        m_bal = m_bal - a;
        m_uf  = 0;
      end else begin
        t     = m_def + (a - m_bal);
        m_bal = 0;
        m_uf  = 1;
        if (m_cnt < 65535) m_cnt++;
        if (t > 255) begin
          m_def = 255;
          m_sat = 1;
        end else begin
          m_def = t;
        end
      end
    end else begin
      m_uf = 0;
      if (m_def >= a) begin
        m_def = m_def - a;
      end else begin
        t     = m_bal + (a - m_def);
        m_def = 0;
        m_bal = (t > 255) ? 255 : t;
      end
    end
  endtask

  task automatic check_out(input string tag, input logic exp_valid);
    chk({tag, "_valid"}, bus.out_valid, exp_valid);
    chk({tag, "_bal"},   bus.out_bal, m_bal);
    chk({tag, "_def"},   bus.out_def, m_def);
    chk({tag, "_uf"},    exp_valid ? bus.out_uf : 1'b0, exp_valid ? m_uf : 0);
    chk({tag, "_sat"},   def_sat, m_sat);
    chk({tag, "_state"}, dut.r_state, model_state());
`ifdef UBALANCE_STATS_EN
    chk({tag, "_cnt"},   uf_count, m_cnt);
`endif
  endtask

  task automatic txn(input op_t op, input logic [7:0] amt, input string tag);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_amt   = amt;
    #1;
    chk({tag, "_rdy"}, bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    model(op, int'(amt));
    check_out(tag, 1'b1);
  endtask

  task automatic do_clr(input string tag);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_zero();
    check_out(tag, 1'b0);
  endtask

  initial begin
    rst           = 1'b1;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_CREDIT;
    bus.in_amt    = '0;
    bus.out_ready = 1'b1;

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    check_out("rst", 1'b0);
    chk("rst_rdy", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_out("idle", 1'b0);

    // Directed arithmetic
    txn(OP_CREDIT, 8'd100, "cr100");
    txn(OP_DEBIT,  8'd30,  "db30");
    txn(OP_DEBIT,  8'd100, "db100_uf");
    txn(OP_CREDIT, 8'd10,  "cr10");
    txn(OP_CREDIT, 8'd50,  "cr50");
    txn(OP_DEBIT,  8'd230, "db230");
    txn(OP_DEBIT,  8'd100, "db100_sat");
    txn(OP_CREDIT, 8'd255, "cr255");
    txn(OP_DEBIT,  8'd0,   "db0");
    txn(OP_CREDIT, 8'd0,   "cr0");
    do_clr("clr_sat");
    txn(OP_CREDIT, 8'd250, "cr250");
    txn(OP_CREDIT, 8'd10,  "cr10_clamp");

    // Backpressure: result must hold while the sink stalls
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = OP_DEBIT;
    bus.in_amt   = 8'd5;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    model(OP_DEBIT, 5);
    check_out("bp_acc", 1'b1);
    bus.in_amt = 8'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rdy_low", bus.in_ready, 0);
      @(posedge clk);
      #1;
      check_out("bp_hold", 1'b1);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rdy_high", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    model(OP_DEBIT, 7);
    check_out("bp_release", 1'b1);

    // clr beats a simultaneous transaction
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = OP_CREDIT;
    bus.in_amt   = 8'd40;
    clr          = 1'b1;
    @(posedge clk);
    #1;
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    model_zero();
    check_out("clr_drop", 1'b0);

    // Three underflowing debits from an empty account
    txn(OP_DEBIT, 8'd5, "uf1");
    txn(OP_DEBIT, 8'd6, "uf2");
    txn(OP_DEBIT, 8'd7, "uf3");
`ifdef UBALANCE_STATS_EN
    chk("uf_count3", uf_count, 3);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_clr("rnd_clr");
      end else begin
        txn(($urandom_range(0, 1) == 1) ? OP_DEBIT : OP_CREDIT,
            8'($urandom_range(0, 255)), "rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
